vga_fb_scanout: RTL and testbench
=================================

Name: vga_fb_scanout

Overview:
- Sits directly downstream of the VGA timing generator (800x600 active, 1056x628 total).
- Holds a 1-bit-per-pixel framebuffer, 800x600. The line-drawing engine writes plotted points into it through a valid/ready port.
- Scans the framebuffer out in step with the incoming hcount/vcount and produces 12-bit RGB, with sync and blank delayed to match the read latency.
- Provides a full-frame clear sequencer.

Parameters:
- H_ACTIVE, 800: active pixels per line; x range is 0..H_ACTIVE-1.
- V_ACTIVE, 600: active lines per frame; y range is 0..V_ACTIVE-1.
- FG_COLOR, 12'hFFF: RGB444 colour for a set pixel.
- BG_COLOR, 12'h000: RGB444 colour for a clear pixel.

Ports:
- pclk  in  1  pixel clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- hcount_in  in  11  horizontal count from the timing generator.
- vcount_in  in  11  vertical count from the timing generator.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator.
- hblnk_in  in  1  horizontal blank from the timing generator.
- vblnk_in  in  1  vertical blank from the timing generator.
- pt_valid  in  1  plot request from the line engine.
- pt_ready  out  1  block can accept a plot this cycle.
- pt_x  in  11  plot x coordinate.
- pt_y  in  11  plot y coordinate.
- clr_start  in  1  single-cycle pulse that starts a full-frame clear.
- clr_busy  out  1  high while a clear is in progress.
- hsync_out  out  1  hsync_in delayed 2 cycles.
- vsync_out  out  1  vsync_in delayed 2 cycles.
- hblnk_out  out  1  hblnk_in delayed 2 cycles.
- vblnk_out  out  1  vblnk_in delayed 2 cycles.
- rgb_out  out  12  pixel colour, aligned with the delayed timing signals.

Behaviour:
- Clock and reset: one clock, pclk. rst is synchronous and active-high.
- Framebuffer:
  - 480000 x 1 bit, address = y*H_ACTIVE + x (19 bits).
  - Simple dual-port: one synchronous write port, one synchronous read port.
  - Read-during-write to the same address returns the old data.
  - Contents are not initialised or affected by rst.
- Scan pipeline, latency exactly 2 cycles:
  - Stage 1 registers rd_addr = vcount_in*H_ACTIVE + hcount_in, computed only when !hblnk_in && !vblnk_in; otherwise rd_addr holds its value. Stage 1 also registers the four timing bits.
  - Stage 2 registers the memory output and the four timing bits again.
  - rgb_out = (hblnk_out || vblnk_out) ? 12'h000 : (pixel ? FG_COLOR : BG_COLOR).
  - rgb_out is zero whenever blanked, regardless of framebuffer contents.
- FSM states IDLE and CLEAR; reset state is IDLE.
- IDLE:
  - pt_ready = !clr_start (combinational).
  - On pt_valid && pt_ready: if pt_x < H_ACTIVE and pt_y < V_ACTIVE, write 1 to address pt_y*H_ACTIVE + pt_x in that cycle. Otherwise the point is accepted and discarded, with no write.
  - Setting an already-set pixel is harmless.
  - On clr_start, go to CLEAR with clr_addr = 0.
- CLEAR:
  - pt_ready = 0 and clr_busy = 1.
  - Write 0 to clr_addr every cycle, then increment it.
  - After writing address 479999, return to IDLE. The next cycle has clr_busy = 0, for a total of 480000 busy cycles.
  - clr_start while in CLEAR is ignored and does not restart the clear.
- clr_start and pt_valid in the same IDLE cycle: the clear wins, and the point is not accepted because pt_ready = 0.
- The scan read runs independently of writes and clears; there is no stalling or arbitration between them.
- Width rules:
  - Address multiply-add is 19 bits unsigned.
  - Coordinates are 11-bit unsigned. Any value >= H_ACTIVE or >= V_ACTIVE is out of range (covers 11'h7FF).
- Reset values:
  - hsync_out = 0, vsync_out = 0, hblnk_out = 1, vblnk_out = 1, rgb_out = 0.
  - clr_busy = 0, state = IDLE, rd_addr = 0, clr_addr = 0.
  - pt_ready returns to 1 (when clr_start = 0) in the cycle after rst deasserts.
- Reset during CLEAR aborts the clear immediately; the framebuffer is left partially cleared.
- The timing inputs are trusted; their wrap at 1055/627 needs no special handling beyond the blank gating.

Test Plan:
- Reset alignment: assert rst 3 cycles with timing running -> outputs at reset values; after release, hsync_out equals hsync_in from exactly 2 cycles earlier, checked across the hsync window 840..967.
- Single plot: clear, then plot (0,0), (799,599), (400,300) -> rgb_out = 12'hFFF exactly at those hcount/vcount positions delayed 2 cycles; all other active pixels 12'h000; blanked cycles 12'h000.
- Out of range: plot (800,0), (0,600), (2047,2047) -> each handshake completes (pt_ready = 1), no pixel changes anywhere in the next frame.
- Clear timing: pulse clr_start with pixels set -> clr_busy high for exactly 480000 cycles, pt_ready low throughout; a second clr_start mid-clear does not extend it; next frame all active pixels 12'h000.
- Collision: clr_start and pt_valid with (10,10) in the same cycle -> pt_ready = 0 that cycle; after the clear completes, (10,10) is not set; re-presenting it sets it.
- Reset mid-clear: rst at busy cycle 1000 -> clr_busy = 0 next cycle, pt_ready = 1; addresses 0..~999 read 0 and previously set pixels beyond that still read FG_COLOR.

Source files
------------

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout
//   1-bit-per-pixel framebuffer sitting behind the VGA timing generator.
//   The line engine plots points through a valid/ready port. The framebuffer
//   is scanned out in step with hcount/vcount, giving RGB444 with the timing
//   signals delayed to match the 2-cycle read latency. A clear sequencer
//   zeroes the whole framebuffer, one word per cycle.
//
// Ports
//   pclk, rst                   pixel clock, synchronous active-high reset
//   hcount_in, vcount_in        raster position from the timing generator
//   hsync_in, vsync_in          sync from the timing generator
//   hblnk_in, vblnk_in          blanking from the timing generator
//   pt_valid, pt_ready          plot handshake
//   pt_x, pt_y                  plot coordinates (out-of-range points are dropped)
//   clr_start, clr_busy         full-frame clear pulse and busy flag
//   hsync_out .. vblnk_out      timing inputs delayed 2 cycles
//   rgb_out                     pixel colour aligned with the delayed timing
//
// State table
//   IDLE  | accept plots; clr_start launches a clear
//   CLEAR | write 0 to clr_addr each cycle until the last address is written
module vga_fb_scanout #(
  parameter int          H_ACTIVE = 800,
  parameter int          V_ACTIVE = 600,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [10:0] pt_x,
  input  logic [10:0] pt_y,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int          FB_SIZE = H_ACTIVE * V_ACTIVE;
  localparam logic [18:0] FB_LAST = 19'(FB_SIZE - 1);
  localparam logic [18:0] H_MUL   = 19'(H_ACTIVE);
  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state, state_nxt;
  logic [18:0] clr_addr, clr_addr_nxt;

  logic        wr_en;
  logic [18:0] wr_addr;
  logic        wr_data;

  logic [18:0] rd_addr;
  logic        pixel;
  logic        s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;

  logic        mem [FB_SIZE];

  logic        pt_in_range;
  logic [18:0] pt_addr;

  assign pt_in_range = (pt_x < H_LIM) && (pt_y < V_LIM);
  assign pt_addr     = 19'(pt_y) * H_MUL + 19'(pt_x);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      CLEAR: begin
        if (clr_addr == FB_LAST) begin
          state_nxt    = IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + 19'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        clr_addr_nxt = '0;
      end
    endcase
  end

  // ---------------- FSM: outputs / write port ----------------
  // Writes are suppressed while rst is high so a reset during a clear stops
  // the clear in the very cycle it is asserted.
  always_comb begin
    pt_ready = 1'b0;
    clr_busy = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = 1'b0;
    case (state)
      IDLE: begin
        pt_ready = !clr_start && !rst;
        if (pt_valid && pt_ready && pt_in_range) begin
          wr_en   = 1'b1;
          wr_addr = pt_addr;
          wr_data = 1'b1;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        wr_en    = !rst;
        wr_addr  = clr_addr;
        wr_data  = 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------- framebuffer (simple dual port, read-old-data) ----------------
  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    pixel <= mem[rd_addr];
  end

  // ---------------- scan pipeline ----------------
  // rd_addr only tracks the raster inside the active area, so it never
  // points outside the framebuffer while the counters run through blanking.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rd_addr   <= '0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_hblnk  <= 1'b1;
      s1_vblnk  <= 1'b1;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      hblnk_out <= 1'b1;
      vblnk_out <= 1'b1;
    end else begin
      if (!hblnk_in && !vblnk_in) begin
        rd_addr <= 19'(vcount_in) * H_MUL + 19'(hcount_in);
      end
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
      s1_hblnk  <= hblnk_in;
      s1_vblnk  <= vblnk_in;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
      hblnk_out <= s1_hblnk;
      vblnk_out <= s1_vblnk;
    end
  end

  always_comb begin
    if (hblnk_out || vblnk_out) rgb_out = 12'h000;
    else                        rgb_out = pixel ? FG_COLOR : BG_COLOR;
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
module tb_vga_fb_scanout;

  // Reduced raster keeps full clears and full frames affordable in simulation.
  localparam int H  = 80;
  localparam int V  = 50;
  localparam int HT = H + 8;
  localparam int VT = V + 3;
  localparam int FB = H * V;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b1, vblnk_in = 1'b1;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [10:0] pt_x = '0, pt_y = '0;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  vga_fb_scanout #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // reference picture: fb[y][x] is 1 when the pixel has been plotted
  bit fb [V][H];

  typedef struct {
    int unsigned due;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } exp_t;
  exp_t exp_q[$];

  // monitor: the pipeline presents one pixel per cycle; pop whatever is due
  always @(negedge pclk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.due != cyc ||
          {hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !==
          {e.hs, e.vs, e.hb, e.vb, e.rgb}) begin
        errors++;
        $display("FAIL scan cyc=%0d due=%0d got hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h exp hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h",
                 cyc, e.due, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
                 e.hs, e.vs, e.hb, e.vb, e.rgb);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic ras_hs(input int h);
    return (h >= H + 2) && (h < H + 6);
  endfunction

  function automatic logic ras_vs(input int v);
    return v == V + 1;
  endfunction

  // Called at posedge+1; drives one raster position and returns at the next posedge+1.
  task automatic drive_scan(input int h, input int v, input logic hs, input logic vs,
                            input logic hb, input logic vb, input bit track);
    exp_t e;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    if (track) begin
      e.due = cyc + 2;
      e.hs  = hs;
      e.vs  = vs;
      e.hb  = hb;
      e.vb  = vb;
      if (hb || vb) e.rgb = 12'h000;
      else          e.rgb = fb[v][h] ? FG : BG;
      exp_q.push_back(e);
    end
    @(posedge pclk); #1;
  endtask

  task automatic park(input int n);
    for (int i = 0; i < n; i++) drive_scan(H, V, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic scan_frame();
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++)
        drive_scan(h, v, ras_hs(h), ras_vs(v), h >= H, v >= V, 1'b1);
    park(3);
  endtask

  task automatic plot(input int x, input int y);
    pt_valid = 1'b1;
    pt_x = 11'(x);
    pt_y = 11'(y);
    @(negedge pclk);
    chk("plot_ready", pt_ready, 1);
    @(posedge pclk); #1;
    pt_valid = 1'b0;
    if (x < H && y < V) fb[y][x] = 1'b1;
  endtask

  // random in-range point outside the address window where a reset-aborted clear stops
  task automatic plot_safe();
    int x, y;
    do begin
      x = $urandom_range(0, H - 1);
      y = $urandom_range(0, V - 1);
    end while (y * H + x >= 900 && y * H + x <= 1100);
    plot(x, y);
  endtask

  task automatic clear_model(input int n);
    for (int i = 0; i < n; i++) fb[i / H][i % H] = 1'b0;
  endtask

  task automatic do_clear(input bit collide, input int restart_at);
    int busy, bad;
    clr_start = 1'b1;
    if (collide) begin
      pt_valid = 1'b1;
      pt_x = 11'd10;
      pt_y = 11'd10;
    end
    @(negedge pclk);
    chk("ready_on_clr_start", pt_ready, 0);
    @(posedge pclk); #1;
    clr_start = 1'b0;
    pt_valid  = 1'b0;
    busy = 0;
    bad  = 0;
    for (int i = 0; i < 2 * FB + 10; i++) begin
      @(negedge pclk);
      if (clr_start) clr_start = 1'b0;
      if (!clr_busy) break;
      busy++;
      if (pt_ready) bad++;
      if (busy == restart_at) clr_start = 1'b1;
    end
    chk("clr_busy_cycles", busy, FB);
    chk("ready_low_in_clear", bad, 0);
    chk("ready_after_clear", pt_ready, 1);
    clear_model(FB);
    @(posedge pclk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    @(posedge pclk); #1;

    // reset with the raster running inside the hsync window
    for (int i = 0; i < 3; i++) begin
      drive_scan(H + 2 + i, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst_outputs", {hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out},
          {4'b0011, 12'h000});
      chk("rst_clr_busy", clr_busy, 0);
    end
    rst = 1'b0;
    #1;
    chk("ready_after_rst", pt_ready, 1);

    // two vertical-blank lines: timing alignment only, picture still unknown
    for (int v = V; v < V + 2; v++)
      for (int h = 0; h < HT; h++)
        drive_scan(h, v, ras_hs(h), ras_vs(v), h >= H, 1'b1, 1'b1);
    park(3);

    do_clear(1'b0, 100);

    plot(0, 0);
    plot(H - 1, V - 1);
    plot(H / 2, V / 2);
    for (int i = 0; i < 20; i++) plot_safe();
    scan_frame();

    plot(H, 0);
    plot(0, V);
    plot(2047, 2047);
    scan_frame();

    do_clear(1'b0, 2000);
    scan_frame();

    do_clear(1'b1, 0);
    plot(20, 20);
    scan_frame();
    plot(10, 10);
    scan_frame();

    // reset during a clear
    for (int i = 0; i < 30; i++) plot_safe();
    plot(0, 1);
    clr_start = 1'b1;
    @(posedge pclk); #1;
    clr_start = 1'b0;
    busy = 0;
    for (int i = 0; i < 2 * FB; i++) begin
      @(negedge pclk);
      if (!clr_busy) break;
      busy++;
      if (busy == 1000) begin
        rst = 1'b1;
        break;
      end
    end
    chk("abort_busy_reached", busy, 1000);
    @(negedge pclk);
    rst = 1'b0;
    #1;
    chk("abort_clr_busy", clr_busy, 0);
    chk("abort_ready", pt_ready, 1);
    clear_model(999);
    @(posedge pclk); #1;
    scan_frame();

    // randomized mix of plots and raster positions
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        plot(($urandom_range(0, 7) == 0) ? $urandom_range(H, 2047) : $urandom_range(0, H - 1),
             ($urandom_range(0, 7) == 0) ? $urandom_range(V, 2047) : $urandom_range(0, V - 1));
      end else begin
        logic hb, vb;
        int h, v;
        hb = ($urandom_range(0, 3) == 0);
        vb = ($urandom_range(0, 5) == 0);
        h  = hb ? $urandom_range(H, HT - 1) : $urandom_range(0, H - 1);
        v  = vb ? $urandom_range(V, VT - 1) : $urandom_range(0, V - 1);
        drive_scan(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hb, vb, 1'b1);
      end
    end
    park(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
